// File: rtl/dct_stage1_rd.sv
// Transposing reader for the stage-1 8x8 DCT buffer: after blk_done it streams
// the buffer out one row per valid/ready beat, then pulses buf_release.
module dct_stage1_rd #(
    parameter int SIZE = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          blk_done,
    input  logic signed [7:0][7:0][SIZE-1:0] buf_data,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic signed [7:0][SIZE-1:0]   out_data,
    output logic [2:0]                    out_row,
    output logic                          out_last,
    output logic                          buf_release,
    output logic                          busy,
    output logic                          err_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [2:0]             row_reg, row_next;
    logic                   valid_reg, valid_next;
    logic                   last_reg, last_next;
    logic                   release_reg, release_next;
    logic                   err_reg, err_next;
    logic [7:0][SIZE-1:0]   data_reg, data_next;

    // Row to fetch on a load edge: row 0 from IDLE, the following row while streaming.
    logic [2:0]             load_row;
    logic [7:0][SIZE-1:0]   lane_sel;

    assign load_row = (state_reg == STREAM) ? row_reg + 3'd1 : 3'd0;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_sel[gi] = buf_data[gi][load_row];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            row_reg     <= 3'd0;
            valid_reg   <= 1'b0;
            last_reg    <= 1'b0;
            release_reg <= 1'b0;
            err_reg     <= 1'b0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            row_reg     <= row_next;
            valid_reg   <= valid_next;
            last_reg    <= last_next;
            release_reg <= release_next;
            err_reg     <= err_next;
            data_reg    <= data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        valid_next   = valid_reg;
        last_next    = last_reg;
        release_next = 1'b0;
        data_next    = data_reg;
        // A block announced while one is still in flight is flagged but never restarts it.
        err_next     = err_reg | (blk_done && (state_reg != IDLE));

        case (state_reg)
            IDLE: begin
                if (blk_done) begin
                    data_next  = lane_sel;
                    row_next   = 3'd0;
                    valid_next = 1'b1;
                    last_next  = 1'b0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (valid_reg && out_ready) begin
                    if (row_reg == 3'd7) begin
                        valid_next   = 1'b0;
                        last_next    = 1'b0;
                        release_next = 1'b1;
                        state_next   = RELEASE;
                    end else begin
                        data_next = lane_sel;
                        row_next  = load_row;
                        last_next = (load_row == 3'd7);
                    end
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end
        endcase
    end

    assign out_valid   = valid_reg;
    assign out_data    = data_reg;
    assign out_row     = row_reg;
    assign out_last    = last_reg;
    assign buf_release = release_reg;
    assign busy        = (state_reg != IDLE);
    assign err_overrun = err_reg;

endmodule

// File: tb/tb_dct_stage1_rd.sv
// Scoreboard bench for dct_stage1_rd: expected rows are queued when a block is
// started and compared as the reader hands them to the stage-2 side.
module tb_dct_stage1_rd;

    localparam int SZ = 10;

    typedef struct packed {
        logic [7:0][SZ-1:0] data;
        logic [2:0]         row;
        logic               last;
    } beat_t;

    logic                          clk;
    logic                          rst;
    logic                          blk_done;
    logic signed [7:0][7:0][SZ-1:0] buf_data;
    logic                          out_ready;
    logic                          out_valid;
    logic signed [7:0][SZ-1:0]     out_data;
    logic [2:0]                    out_row;
    logic                          out_last;
    logic                          buf_release;
    logic                          busy;
    logic                          err_overrun;

    int    n_vec;
    int    n_err;
    beat_t sb[$];

    dct_stage1_rd #(.SIZE(SZ)) dut (
        .clk         (clk),
        .rst         (rst),
        .blk_done    (blk_done),
        .buf_data    (buf_data),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .buf_release (buf_release),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: 16*c+e ramp, mode 1: alternating -512/+511, mode 2: second ramp.
    task automatic fill(input int mode);
        for (int c = 0; c < 8; c++) begin
            for (int e = 0; e < 8; e++) begin
                int v;
                case (mode)
                    0:       v = 16 * c + e;
                    1:       v = ((c + e) % 2 == 1) ? 511 : -512;
                    default: v = 300 - 37 * c - 5 * e;
                endcase
                buf_data[c][e] = SZ'(v);
            end
        end
    endtask

    // Pulses blk_done while the reader is idle and queues the eight transposed rows.
    task automatic start_block(input int mode);
        beat_t b;
        fill(mode);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) b.data[c] = buf_data[c][r];
            b.row  = 3'(r);
            b.last = (r == 7);
            sb.push_back(b);
        end
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        chk("latency_valid", {127'd0, out_valid}, 128'd1);
        chk("latency_row",   {125'd0, out_row},   128'd0);
        chk("busy_stream",   {127'd0, busy},      128'd1);
    endtask

    // Drives out_ready from an 8-entry pattern until buf_release shows, then one more cycle.
    task automatic drain(input logic [7:0] pat, output int cycles);
        cycles = 0;
        for (int i = 0; i < 60; i++) begin
            out_ready = pat[i % 8];
            tick();
            cycles++;
            if (buf_release) break;
        end
        chk("release_seen", {127'd0, buf_release}, 128'd1);
        tick();
        chk("idle_after_release", {126'd0, busy, out_valid}, 128'd0);
        chk("sb_empty", 128'(sb.size()), 128'd0);
    endtask

    // Output monitor: pops on every handshake, checks holds during stalls and
    // that buf_release follows the row-7 handshake by exactly one cycle.
    logic       rel_pending;
    logic       stall_prev;
    beat_t      held;
    initial begin
        rel_pending = 1'b0;
        stall_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rel_pending = 1'b0;
                stall_prev  = 1'b0;
            end else begin
                chk("buf_release", {127'd0, buf_release}, {127'd0, rel_pending});
                rel_pending = 1'b0;
                if (stall_prev) begin
                    chk("stall_valid", {127'd0, out_valid}, 128'd1);
                    chk("stall_hold", {44'd0, out_data, out_row, out_last}, {44'd0, held});
                end
                stall_prev = out_valid && !out_ready;
                held = {out_data, out_row, out_last};
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", 128'd1, 128'd0);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        chk("beat", {44'd0, out_data, out_row, out_last}, {44'd0, e});
                    end
                    if (out_last) rel_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        int cyc;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b0;
        blk_done  = 1'b0;
        out_ready = 1'b0;
        buf_data  = '0;
        tick();
        tick();
        chk("rst_state", {115'd0, out_valid, out_row, out_last, buf_release, busy, err_overrun},
            128'd0);
        chk("rst_data", {48'd0, out_data}, 128'd0);
        rst = 1'b1;
        tick();

        // Basic transpose with out_ready held high.
        start_block(0);
        drain(8'hFF, cyc);
        chk("release_cycle", 128'(cyc), 128'd8);

        // Backpressure: 1,0,0,1,0,1,1,1 (bit 0 first).
        start_block(0);
        drain(8'b1110_1001, cyc);

        // Signed extremes.
        start_block(1);
        drain(8'hFF, cyc);

        // Overrun during row 3 and in the release cycle.
        start_block(0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("ovr_row3", {125'd0, out_row}, 128'd3);
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        chk("ovr_err", {127'd0, err_overrun}, 128'd1);
        chk("ovr_continue", {124'd0, out_valid, out_row}, {124'd0, 1'b1, 3'd4});
        for (int i = 0; i < 4; i++) tick();
        chk("ovr_release", {127'd0, buf_release}, 128'd1);
        blk_done = 1'b1;
        tick();
        blk_done = 1'b0;
        chk("ovr_ignored", {125'd0, err_overrun, busy, out_valid}, {125'd0, 3'b100});
        start_block(2);
        drain(8'hFF, cyc);
        chk("ovr_sticky", {127'd0, err_overrun}, 128'd1);

        // Asynchronous reset during row 5.
        start_block(1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_row", {125'd0, out_row}, 128'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst", {124'd0, out_valid, busy, buf_release, err_overrun}, 128'd0);
        chk("async_rst_data", {48'd0, out_data}, 128'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_quiet", {126'd0, out_valid, buf_release}, 128'd0);
        end
        start_block(0);
        drain(8'hFF, cyc);

        // Back-to-back blocks: second blk_done in the first IDLE cycle.
        start_block(2);
        drain(8'hFF, cyc);
        start_block(1);
        drain(8'hFF, cyc);
        chk("b2b_no_overrun", {127'd0, err_overrun}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
